// File: rtl/ram_b.sv
// Single-port synchronous data RAM with a registered read port and a selectable write mode.
// Optional macro RAM_B_OUT_REG_EN adds a second output register, giving a read latency of 2.
module ram_b #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int WRITE_MODE = 0   // 0 write-first, 1 read-first, 2 no-change
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    output logic [DATA_W-1:0] douta
);

    localparam int DEPTH = 2 ** ADDR_W;

    // The declaration initialiser gives all-zero power-up contents in simulation and synthesis.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] r_stage1;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_stage1_d;

    // NOTE: the array has no reset branch; a memory cannot be cleared in one cycle, and a reset
    // term would stop it mapping onto block RAM. Writes also commit while rsta_n is low.
    always_ff @(posedge clka) begin
        if (wea) begin
            r_mem[addra] <= dina;
        end
    end

    assign w_rd_data = r_mem[addra];

    // NOTE: the default assignment comes first, so every path through this block drives
    // w_stage1_d and no latch is inferred.
    always_comb begin
        w_stage1_d = r_stage1;
        if (!wea) begin
            w_stage1_d = w_rd_data;
        end else if (WRITE_MODE == 0) begin
            w_stage1_d = dina;
        end else if (WRITE_MODE == 1) begin
            w_stage1_d = w_rd_data;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_stage1 <= '0;
        end else begin
            r_stage1 <= w_stage1_d;
        end
    end

`ifdef RAM_B_OUT_REG_EN
    logic [DATA_W-1:0] r_stage2;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_stage2 <= '0;
        end else begin
            r_stage2 <= r_stage1;
        end
    end

    assign douta = r_stage2;
`else
    assign douta = r_stage1;
`endif

endmodule

// File: tb/tb_ram_b.sv
// Table-driven bench for ram_b: three instances (write-first, read-first, no-change) share stimulus.
// Expected values are the first-stage output; with RAM_B_OUT_REG_EN they are checked one edge later.
module tb_ram_b;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [31:0] din;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        wea;
    logic [5:0]  addra;
    logic [31:0] dina;
    logic [31:0] dout0, dout1, dout2;

    int errors = 0;
    int checks = 0;

    vec_t tab_a[$];
    vec_t tab_b[$];
    logic [31:0] exp_prev[3];

    ram_b #(.DATA_W(32), .ADDR_W(6), .WRITE_MODE(0)) u_wf (
        .clka(clk), .rsta_n(rst_n), .wea(wea), .addra(addra), .dina(dina), .douta(dout0));
    ram_b #(.DATA_W(32), .ADDR_W(6), .WRITE_MODE(1)) u_rf (
        .clka(clk), .rsta_n(rst_n), .wea(wea), .addra(addra), .dina(dina), .douta(dout1));
    ram_b #(.DATA_W(32), .ADDR_W(6), .WRITE_MODE(2)) u_nc (
        .clka(clk), .rsta_n(rst_n), .wea(wea), .addra(addra), .dina(dina), .douta(dout2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic void add(input bit seg, input logic we, input logic [5:0] addr,
                                input logic [31:0] din, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        if (seg) tab_b.push_back(v);
        else     tab_a.push_back(v);
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        logic [31:0] e[3];
        @(negedge clk);
        wea   = v.we;
        addra = v.addr;
        dina  = v.din;
        @(posedge clk);
        #1;
`ifdef RAM_B_OUT_REG_EN
        e = exp_prev;
`else
        e[0] = v.e0; e[1] = v.e1; e[2] = v.e2;
`endif
        check({tag, " wf"}, dout0, e[0]);
        check({tag, " rf"}, dout1, e[1]);
        check({tag, " nc"}, dout2, e[2]);
        exp_prev[0] = v.e0; exp_prev[1] = v.e1; exp_prev[2] = v.e2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wf"}, dout0, 32'h0);
        check({tag, " rf"}, dout1, 32'h0);
        check({tag, " nc"}, dout2, 32'h0);
    endtask

    initial begin
        // Segment A: post-reset reads, write burst, readback, write-mode check, addr 63 write.
        for (int a = 0; a < 10; a++) add(0, 1'b0, 6'(a), 32'h0, 32'h0, 32'h0, 32'h0);
        add(0, 1'b1, 6'd1,  32'hA0A0A0A0, 32'hA0A0A0A0, 32'h0, 32'h0);
        add(0, 1'b1, 6'd3,  32'h0B0B0B0B, 32'h0B0B0B0B, 32'h0, 32'h0);
        add(0, 1'b1, 6'd5,  32'h0C0C0C0C, 32'h0C0C0C0C, 32'h0, 32'h0);
        add(0, 1'b1, 6'd8,  32'hD0D0D0D0, 32'hD0D0D0D0, 32'h0, 32'h0);
        add(0, 1'b1, 6'd9,  32'h50505050, 32'h50505050, 32'h0, 32'h0);
        add(0, 1'b1, 6'd10, 32'h70707070, 32'h70707070, 32'h0, 32'h0);
        add(0, 1'b1, 6'd12, 32'h65432121, 32'h65432121, 32'h0, 32'h0);
        begin
            logic [31:0] rb[13];
            rb = '{32'h0, 32'hA0A0A0A0, 32'h0, 32'h0B0B0B0B, 32'h0, 32'h0C0C0C0C, 32'h0,
                   32'h0, 32'hD0D0D0D0, 32'h50505050, 32'h70707070, 32'h0, 32'h65432121};
            for (int a = 0; a < 13; a++) add(0, 1'b0, 6'(a), 32'hFFFFFFFF, rb[a], rb[a], rb[a]);
        end
        add(0, 1'b1, 6'd1,  32'h11111111, 32'h11111111, 32'hA0A0A0A0, 32'h65432121);
        add(0, 1'b0, 6'd1,  32'h0,        32'h11111111, 32'h11111111, 32'h11111111);
        add(0, 1'b1, 6'd63, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h11111111);
        // Segment B: after a reset pulse that overlapped a write to addr 62.
        add(1, 1'b0, 6'd63, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        add(1, 1'b0, 6'd62, 32'h0, 32'h12345678, 32'h12345678, 32'h12345678);
        add(1, 1'b1, 6'd7,  32'h1, 32'h1, 32'h0, 32'h12345678);
        add(1, 1'b1, 6'd7,  32'h2, 32'h2, 32'h1, 32'h12345678);
        add(1, 1'b0, 6'd7,  32'h0, 32'h2, 32'h2, 32'h2);
        add(1, 1'b0, 6'd12, 32'h0, 32'h65432121, 32'h65432121, 32'h65432121);

        rst_n = 1'b0;
        wea   = 1'b0;
        addra = '0;
        dina  = '0;
        exp_prev = '{32'h0, 32'h0, 32'h0};
        #1;
        check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tab_a[i]) apply_vec(tab_a[i], $sformatf("a%0d", i));

        // Reset asserted mid-cycle: outputs clear at once; the write at the reset edge commits.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        wea   = 1'b1;
        addra = 6'd62;
        dina  = 32'h12345678;
        #1;
        check_all_zero("rst_immediate");
        @(posedge clk);
        #1;
        check_all_zero("rst_held_edge");
        @(negedge clk);
        rst_n = 1'b1;
        wea   = 1'b0;
        exp_prev = '{32'h0, 32'h0, 32'h0};

        foreach (tab_b[i]) apply_vec(tab_b[i], $sformatf("b%0d", i));

`ifdef RAM_B_OUT_REG_EN
        // Flush the second stage so the final table entry is also checked.
        @(negedge clk);
        wea = 1'b0;
        @(posedge clk);
        #1;
        check("flush wf", dout0, exp_prev[0]);
        check("flush rf", dout1, exp_prev[1]);
        check("flush nc", dout2, exp_prev[2]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_b.md
Name: ram_b

Overview:
- Single-port synchronous data RAM, 64 words x 32 bits, used as the processor data memory behind the load/store path.
- The CPU drives a word address (byte address bits [7:2]), a write enable and write data.
- Read data appears on a registered output one clock after the address is sampled.
- Drop-in equivalent of a block-memory-generator single-port RAM (port A only).

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 6, word address width; depth = 2**ADDR_W (64).
- WRITE_MODE, 0, output behaviour on a write cycle: 0 = write-first, 1 = read-first, 2 = no-change.

Ports:
- clka  input  1  clock; all sampling on the rising edge.
- rsta_n  input  1  asynchronous active-low reset; clears the output register only.
- wea  input  1  write enable, active high.
- addra  input  ADDR_W  word address.
- dina  input  DATA_W  write data.
- douta  output  DATA_W  registered read data.

Behaviour:
- Reset: rsta_n low forces douta = 0 immediately, independent of clka, and holds it while low.
- Reset does not alter memory contents.
- Reset deassertion is sampled at the next rising edge; the first edge with rsta_n high performs a normal access.
- Power-up contents: every word initialised to 0 (simulation initial block and synthesis init value).
- Read (wea = 0): at a rising edge, douta <= mem[addra].
  - Latency is exactly 1 cycle.
  - douta holds its value between edges.
  - douta changes only on edges or on reset.
- Write (wea = 1): at a rising edge, mem[addra] <= dina (full-word write, no byte enables).
- douta on a write edge, per WRITE_MODE:
  - 0 (write-first): douta <= dina.
  - 1 (read-first): douta <= old mem[addra].
  - 2 (no-change): douta holds its previous value.
- A write takes effect for reads on the following edge: a read of the same address on the next cycle returns the new data.
- Address range: all 64 addresses are valid. There is no out-of-range case; addra is exactly ADDR_W bits.
- Consecutive writes to different addresses on back-to-back edges are all committed.
- Writing the same address twice keeps the last value.
- wea, addra and dina are sampled only at rising edges; glitches between edges have no effect.
- Reset asserted mid-write:
  - If rsta_n is low at the edge, the write still commits to the array.
  - douta stays 0 while reset is low.
- X/undefined dina with wea = 1 is stored as-is; no checking.

Optional Feature:
- Macro RAM_B_OUT_REG_EN.
- Defined:
  - Adds a second pipeline register after douta's first stage.
  - Read latency becomes 2 cycles.
  - Both stages are cleared asynchronously by rsta_n.
  - The write-mode selection applies to the first stage.
- Undefined: single register, latency 1, as above.

Test Plan:
1. Reset then read: assert rsta_n low mid-run -> douta = 0 immediately. Release, read addra 0..9 with wea = 0 -> douta = 0 for each, one cycle after its address.
2. Write burst, WRITE_MODE = 0:
   - Writes: addr 1 = A0A0A0A0, 3 = 0B0B0B0B, 5 = 0C0C0C0C, 8 = D0D0D0D0, 9 = 50505050, 10 = 70707070, 12 = 65432121.
   - Required: douta equals dina on each write edge.
3. Readback after step 2, addra sweeping 0..12 with wea = 0:
   - addr 1, 3, 5, 8, 9, 10, 12 return the step-2 values.
   - addr 0, 2, 4, 6, 7, 11 return 0.
   - Each value appears one edge after its address.
4. Write-mode check at addr 1 (holds A0A0A0A0), write 11111111:
   - WRITE_MODE = 1 -> douta = A0A0A0A0 on the write edge.
   - WRITE_MODE = 2 -> douta keeps its prior value.
   - Next read of addr 1 -> 11111111 in both modes.
5. Reset persistence: write addr 63 = DEADBEEF, pulse rsta_n low, then read addr 63 -> douta = 0 during reset, DEADBEEF one cycle after the read edge.
6. RAM_B_OUT_REG_EN defined: read addr 12 -> 65432121 appears two edges after the address is applied; douta = 0 during reset.
